// File: rtl/convolution_procesor_pkg.sv
// Shared types and constants for the 1-D convolution core.
//   conv_state_t   : sequencing FSM states.
//   DEF_*          : default core configuration.
//   ZADDR_WIDTH    : Z address width (one bit wider than X/Y addresses).
//   PROD_WIDTH     : full X*Y product width.
package convolution_procesor_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned DEF_ACC_WIDTH  = 16;

    localparam int unsigned ZADDR_WIDTH = DEF_ADDR_WIDTH + 1;
    localparam int unsigned PROD_WIDTH  = 2 * DEF_DATA_WIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StCalc,
        StFlush,
        StWrite,
        StDone
    } conv_state_t;

endpackage

// File: rtl/convolution_procesor_register.sv
// Loadable register with synchronous clear, used as the convolution accumulator.
//   clk, rstn : clock, asynchronous active-low reset.
//   enh       : load data_i (wins over clrh).
//   clrh      : synchronous clear.
//   data_i    : next value.
//   data_o    : current value.
module convolution_procesor_register #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enh,
    input  logic                  clrh,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data <= '0;
        end else if (enh) begin
            r_data <= data_i;
        end else if (clrh) begin
            r_data <= '0;
        end
    end

    assign data_o = r_data;

endmodule

// File: rtl/convolution_procesor_core_fsm.sv
// Sequencing engine of the 1-D convolution core: Z[k] = sum_j X[k-j]*Y[j].
//   clk, rstn                 : clock, asynchronous active-low reset.
//   start_i, size_x_i/size_y_i: job request and operand lengths (latched in idle).
//   memx_*/memy_*             : synchronous operand memory read ports (1-cycle latency).
//   memz_addr_o/data_o/we_o   : one write per output sample.
//   clr_o                     : one-cycle pulse at job start.
//   busy_o, done_o            : job in progress / one-cycle completion pulse.
module convolution_procesor_core_fsm
    import convolution_procesor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] size_x_i,
    input  logic [ADDR_WIDTH-1:0] size_y_i,
    output logic [ADDR_WIDTH-1:0] memx_addr_o,
    input  logic [DATA_WIDTH-1:0] memx_data_i,
    output logic [ADDR_WIDTH-1:0] memy_addr_o,
    input  logic [DATA_WIDTH-1:0] memy_data_i,
    output logic [ADDR_WIDTH:0]   memz_addr_o,
    output logic [ACC_WIDTH-1:0]  memz_data_o,
    output logic                  memz_we_o,
    output logic                  clr_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned ZW = ADDR_WIDTH + 1;
    localparam int unsigned PW = 2 * DATA_WIDTH;

    conv_state_t           r_state, w_state_d;
    logic [ADDR_WIDTH-1:0] r_sx, w_sx_d;
    logic [ADDR_WIDTH-1:0] r_sy, w_sy_d;
    logic [ZW-1:0]         r_k, w_k_d;
    logic [ADDR_WIDTH-1:0] r_j, w_j_d;
    logic                  r_valid, w_valid_d;
    logic [ZW-1:0]         r_zaddr;
    logic [ACC_WIDTH-1:0]  r_zdata;

    logic signed [ADDR_WIDTH+1:0] w_diff;
    logic                         w_in_range;
    logic [ZW-1:0]                w_k_last;
    logic [PW-1:0]                w_prod;
    logic [ACC_WIDTH-1:0]         w_acc;
    logic [ACC_WIDTH-1:0]         w_acc_sum;
    logic                         w_acc_clr;

    // Signed k-j, wide enough that negative differences never alias into range.
    assign w_diff     = $signed({1'b0, r_k}) - $signed({2'b00, r_j});
    assign w_in_range = !w_diff[ADDR_WIDTH+1] && (w_diff[ADDR_WIDTH:0] < {1'b0, r_sx});
    assign w_k_last   = ZW'(r_sx) + ZW'(r_sy) - ZW'(2);

    assign w_prod    = PW'(memx_data_i) * PW'(memy_data_i);
    assign w_acc_sum = w_acc + ACC_WIDTH'(w_prod);
    assign w_acc_clr = (r_state == StClear) || (r_state == StWrite);

    convolution_procesor_register #(
        .DATA_WIDTH(ACC_WIDTH)
    ) u_acc (
        .clk    (clk),
        .rstn   (rstn),
        .enh    (r_valid),
        .clrh   (w_acc_clr),
        .data_i (w_acc_sum),
        .data_o (w_acc)
    );

    always_comb begin
        w_state_d = r_state;
        w_sx_d    = r_sx;
        w_sy_d    = r_sy;
        w_k_d     = r_k;
        w_j_d     = r_j;
        w_valid_d = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start_i) begin
                    w_sx_d    = size_x_i;
                    w_sy_d    = size_y_i;
                    w_state_d = (size_x_i != '0 && size_y_i != '0) ? StClear : StDone;
                end
            end
            StClear: begin
                w_k_d     = '0;
                w_j_d     = '0;
                w_state_d = StCalc;
            end
            StCalc: begin
                // Tag travels alongside the 1-cycle memory read latency.
                w_valid_d = w_in_range;
                w_j_d     = r_j + ADDR_WIDTH'(1);
                if (r_j == r_sy - ADDR_WIDTH'(1)) begin
                    w_state_d = StFlush;
                end
            end
            StFlush: begin
                w_state_d = StWrite;
            end
            StWrite: begin
                w_j_d = '0;
                if (r_k == w_k_last) begin
                    w_state_d = StDone;
                end else begin
                    w_k_d     = r_k + ZW'(1);
                    w_state_d = StCalc;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
            r_sx    <= '0;
            r_sy    <= '0;
            r_k     <= '0;
            r_j     <= '0;
            r_valid <= 1'b0;
            r_zaddr <= '0;
            r_zdata <= '0;
        end else begin
            r_state <= w_state_d;
            r_sx    <= w_sx_d;
            r_sy    <= w_sy_d;
            r_k     <= w_k_d;
            r_j     <= w_j_d;
            r_valid <= w_valid_d;
            // Keep the Z port stable between write strobes.
            if (r_state == StWrite) begin
                r_zaddr <= r_k;
                r_zdata <= w_acc;
            end
        end
    end

    assign memx_addr_o = (r_state == StCalc) ? w_diff[ADDR_WIDTH-1:0] : '0;
    assign memy_addr_o = (r_state == StCalc) ? r_j : '0;
    assign memz_we_o   = (r_state == StWrite);
    assign memz_addr_o = memz_we_o ? r_k : r_zaddr;
    assign memz_data_o = memz_we_o ? w_acc : r_zdata;
    assign clr_o       = (r_state == StClear);
    assign busy_o      = (r_state == StClear) || (r_state == StCalc) ||
                         (r_state == StFlush) || (r_state == StWrite);
    assign done_o      = (r_state == StDone);

endmodule

// File: tb/tb_convolution_procesor_core_fsm.sv
module tb_convolution_procesor_core_fsm;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_i;
    logic [4:0]  size_x_i, size_y_i;
    logic [4:0]  memx_addr_o, memy_addr_o;
    logic [7:0]  memx_data_i, memy_data_i;
    logic [5:0]  memz_addr_o;
    logic [15:0] memz_data_o;
    logic        memz_we_o, clr_o, busy_o, done_o;

    convolution_procesor_core_fsm #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(5),
        .ACC_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start_i    (start_i),
        .size_x_i   (size_x_i),
        .size_y_i   (size_y_i),
        .memx_addr_o(memx_addr_o),
        .memx_data_i(memx_data_i),
        .memy_addr_o(memy_addr_o),
        .memy_data_i(memy_data_i),
        .memz_addr_o(memz_addr_o),
        .memz_data_o(memz_data_o),
        .memz_we_o  (memz_we_o),
        .clr_o      (clr_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    // Synchronous operand memories, one cycle read latency.
    logic [7:0] x_mem [32];
    logic [7:0] y_mem [32];
    always @(posedge clk) begin
        memx_data_i <= x_mem[memx_addr_o];
        memy_data_i <= y_mem[memy_addr_o];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Direct definition of the convolution, wrapping modulo 2^16.
    function automatic logic [15:0] model_z(input int k, input int sx, input int sy);
        int unsigned s;
        s = 0;
        for (int j = 0; j < sy; j++) begin
            if (k - j >= 0 && k - j < sx) s += x_mem[k-j] * y_mem[j];
        end
        return s[15:0];
    endfunction

    function automatic int exp_latency(input int sx, input int sy);
        if (sx == 0 || sy == 0) return 1;
        return 2 + (sx + sy - 1) * (sy + 2);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 32; i++) begin
            x_mem[i] = 8'($urandom);
            y_mem[i] = 8'($urandom);
        end
    endtask

    // Observations from the most recent job.
    int          wr_addr [$];
    logic [15:0] wr_data [$];
    int          lat, clr_cnt;
    bit          busy_seen, done_busy;

    task automatic run_job(input int sx, input int sy, input bit disturb);
        wr_addr.delete();
        wr_data.delete();
        clr_cnt   = 0;
        busy_seen = 0;
        done_busy = 0;
        lat       = -1;
        @(posedge clk); #1;
        size_x_i = 5'(sx);
        size_y_i = 5'(sy);
        start_i  = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int cyc = 1; cyc <= 4000; cyc++) begin
            if (disturb && cyc == 3) begin
                start_i  = 1'b1;
                size_x_i = 5'd7;
                size_y_i = 5'd5;
            end
            if (disturb && cyc == 4) start_i = 1'b0;
            if (clr_o) clr_cnt++;
            if (busy_o) busy_seen = 1;
            if (memz_we_o) begin
                wr_addr.push_back(int'(memz_addr_o));
                wr_data.push_back(memz_data_o);
            end
            if (done_o) begin
                lat       = cyc;
                done_busy = busy_o;
                break;
            end
            @(posedge clk); #1;
        end
        if (disturb) begin
            // start raised while in DONE must not launch a job.
            start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
            check("start_in_done_busy", busy_o, 0);
            @(posedge clk); #1;
            check("start_in_done_clr", clr_o, 0);
            check("start_in_done_busy2", busy_o, 0);
        end
    endtask

    task automatic verify_model(input string name, input int sx, input int sy);
        int nz;
        nz = (sx != 0 && sy != 0) ? sx + sy - 1 : 0;
        check({name, "_nwrites"}, wr_addr.size(), nz);
        for (int i = 0; i < nz && i < wr_addr.size(); i++) begin
            check({name, "_zaddr"}, wr_addr[i], i);
            check({name, "_zdata"}, wr_data[i], model_z(i, sx, sy));
        end
        check({name, "_latency"}, lat, exp_latency(sx, sy));
        check({name, "_clr"}, clr_cnt, (nz != 0) ? 1 : 0);
        check({name, "_busy_in_done"}, done_busy, 0);
        check({name, "_busy_seen"}, busy_seen, (nz != 0) ? 1 : 0);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_we"},    memz_we_o,   0);
        check({name, "_zaddr"}, memz_addr_o, 0);
        check({name, "_zdata"}, memz_data_o, 0);
        check({name, "_busy"},  busy_o,      0);
        check({name, "_done"},  done_o,      0);
        check({name, "_clr"},   clr_o,       0);
        check({name, "_xaddr"}, memx_addr_o, 0);
        check({name, "_yaddr"}, memy_addr_o, 0);
    endtask

    typedef struct {
        string          name;
        int             sx;
        int             sy;
        logic [2:0][7:0]  x;
        logic [1:0][7:0]  y;
        int             nz;
        logic [3:0][15:0] z;
        int             lat;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int stray;
        bit found;

        vecs[0] = '{"conv3x2", 3, 2, {8'd3, 8'd2, 8'd1}, {8'd1, 8'd1}, 4,
                    {16'd3, 16'd5, 16'd3, 16'd1}, 18};
        vecs[1] = '{"conv1x1_max", 1, 1, {8'd0, 8'd0, 8'd255}, {8'd0, 8'd255}, 1,
                    {16'd0, 16'd0, 16'd0, 16'd65025}, 5};
        vecs[2] = '{"conv2x2_wrap", 2, 2, {8'd0, 8'd255, 8'd255}, {8'd255, 8'd255}, 3,
                    {16'd0, 16'd65025, 16'd64514, 16'd65025}, 14};
        vecs[3] = '{"sx_zero", 0, 2, {8'd1, 8'd2, 8'd3}, {8'd1, 8'd1}, 0,
                    {16'd0, 16'd0, 16'd0, 16'd0}, 1};
        vecs[4] = '{"sy_zero", 3, 0, {8'd1, 8'd2, 8'd3}, {8'd1, 8'd1}, 0,
                    {16'd0, 16'd0, 16'd0, 16'd0}, 1};

        rstn     = 1'b0;
        start_i  = 1'b0;
        size_x_i = '0;
        size_y_i = '0;
        fill_random();
        #22;
        check_idle_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Table vectors: expected Z values and latency straight from the record.
        for (int v = 0; v < 5; v++) begin
            fill_random();
            for (int i = 0; i < 3; i++) x_mem[i] = vecs[v].x[i];
            for (int i = 0; i < 2; i++) y_mem[i] = vecs[v].y[i];
            run_job(vecs[v].sx, vecs[v].sy, 1'b0);
            check({vecs[v].name, "_nwrites"}, wr_addr.size(), vecs[v].nz);
            for (int i = 0; i < vecs[v].nz && i < wr_addr.size(); i++) begin
                check({vecs[v].name, "_zaddr"}, wr_addr[i], i);
                check({vecs[v].name, "_zdata"}, wr_data[i], vecs[v].z[i]);
            end
            check({vecs[v].name, "_latency"}, lat, vecs[v].lat);
            check({vecs[v].name, "_clr"}, clr_cnt, (vecs[v].nz != 0) ? 1 : 0);
            check({vecs[v].name, "_busy_seen"}, busy_seen, (vecs[v].nz != 0) ? 1 : 0);
            check({vecs[v].name, "_busy_in_done"}, done_busy, 0);
        end

        // Re-start and size changes while in CALC / start in DONE are ignored.
        fill_random();
        x_mem[0] = 8'd1; x_mem[1] = 8'd2; x_mem[2] = 8'd3;
        y_mem[0] = 8'd1; y_mem[1] = 8'd1;
        run_job(3, 2, 1'b1);
        verify_model("disturb", 3, 2);

        // Reset during the WRITE of k=1 aborts the job.
        fill_random();
        @(posedge clk); #1;
        size_x_i = 5'd3;
        size_y_i = 5'd2;
        start_i  = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        found   = 0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            if (memz_we_o && memz_addr_o == 6'd1) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("abort_reached_write_k1", found, 1);
        rstn = 1'b0;
        #1;
        check_idle_outputs("abort");
        @(posedge clk); #1;
        rstn  = 1'b1;
        stray = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (done_o || memz_we_o || busy_o) stray++;
            @(posedge clk); #1;
        end
        check("abort_no_activity", stray, 0);
        run_job(3, 2, 1'b0);
        verify_model("after_abort", 3, 2);

        // Randomized jobs against the reference model.
        for (int r = 0; r < 24; r++) begin
            int sx, sy;
            fill_random();
            if (r == 0) begin
                sx = 31; sy = 31;
            end else if (r == 1) begin
                sx = 1; sy = 31;
            end else begin
                sx = $urandom_range(0, 9);
                sy = $urandom_range(0, 9);
            end
            run_job(sx, sy, 1'b0);
            verify_model($sformatf("rand%0d", r), sx, sy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/convolution_procesor_core_fsm.md
Name: convolution_procesor_core_fsm

Overview:
- Sequencing engine of the 1-D convolution IP core: computes Z[k] = sum over j of X[k-j]*Y[j], for k = 0 .. SX+SY-2.
- Reads operands from the synchronous X and Y memories and issues one write per Z sample toward the result memory/register stage.
- Driven by the host-side start/size registers; reports busy/done back to the interface.

Parameters:
- DATA_WIDTH, 8: X and Y sample width; unsigned.
- ADDR_WIDTH, 5: X/Y address width; SX, SY each ≤ 2^ADDR_WIDTH-1.
- ACC_WIDTH, 16: accumulator and Z data width.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start_i  in  1  start request; sampled in IDLE only.
- size_x_i  in  ADDR_WIDTH  number of X samples (SX).
- size_y_i  in  ADDR_WIDTH  number of Y samples (SY).
- memx_addr_o  out  ADDR_WIDTH  X read address.
- memx_data_i  in  DATA_WIDTH  X read data, valid 1 cycle after address.
- memy_addr_o  out  ADDR_WIDTH  Y read address.
- memy_data_i  in  DATA_WIDTH  Y read data, valid 1 cycle after address.
- memz_addr_o  out  ADDR_WIDTH+1  Z write address (k).
- memz_data_o  out  ACC_WIDTH  Z write data (accumulator value).
- memz_we_o  out  1  Z write strobe; drives downstream enh.
- clr_o  out  1  one-cycle pulse at job start; drives downstream clrh.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; all outputs, counters, accumulator and latched sizes = 0.
- States: IDLE, CLEAR, CALC, FLUSH, WRITE, DONE.
- IDLE:
  - On start_i=1, latch SX and SY.
  - Go to CLEAR if both are nonzero; otherwise go directly to DONE (no writes, no clr_o).
- CLEAR (1 cycle):
  - clr_o=1; k=0, j=0, accumulator=0.
  - Go to CALC.
- CALC (SY cycles per k):
  - Drive memy_addr_o=j and memx_addr_o=(k-j) truncated to ADDR_WIDTH.
  - Register a valid tag, set only when 0 ≤ k-j < SX; compute with an ADDR_WIDTH+2-bit signed difference.
  - On the following cycle: if the tag is set, acc ← acc + X*Y. The product is 2*DATA_WIDTH wide and is zero-extended or truncated to ACC_WIDTH; the sum wraps modulo 2^ACC_WIDTH.
  - Invalid i still consumes a cycle, giving fixed timing.
  - j increments each cycle; after j=SY-1 go to FLUSH.
- FLUSH (1 cycle): accumulates the final read; no new address issued.
- WRITE (1 cycle):
  - memz_we_o=1, memz_addr_o=k, memz_data_o=acc.
  - Accumulator clears at the end of this cycle; j ← 0.
  - If k = SX+SY-2 go to DONE; else k ← k+1 and go to CALC.
- DONE (1 cycle): done_o=1, busy_o=0; then IDLE.
- busy_o=1 in CLEAR, CALC, FLUSH and WRITE.
- memz_we_o is low outside WRITE; memz_addr_o and memz_data_o hold their last values.
- Latency: done_o asserts 2 + (SX+SY-1)*(SY+2) cycles after start_i is sampled.
- start_i is ignored in every state other than IDLE, including DONE.
- Size inputs may change during a job without effect, since the latched copies are used.
- Reset asserted mid-job aborts immediately: no further writes and no done_o.
- Accumulator register: enable has priority over clear; clear coincides only with WRITE, when the valid tag is always 0.

Decomposition:
- Package convolution_procesor_pkg holds:
  - State enum conv_state_t.
  - Localparams ZADDR_WIDTH = ADDR_WIDTH+1 and PROD_WIDTH = 2*DATA_WIDTH.
- Sub-module: the accumulator is an instance of convolution_procesor_register (DATA_WIDTH=ACC_WIDTH).
  - enh = valid tag.
  - data_i = acc + product.
  - clrh = CLEAR or WRITE state.
- The FSM and address counters stay in the top module.

Test Plan:
- X=[1,2,3], Y=[1,1], SX=3, SY=2 -> writes Z[0..3]=[1,3,5,3] on 4 memz_we_o pulses; done_o exactly 18 cycles after start.
- SX=1, SY=1, X=[255], Y=[255] -> single write Z[0]=65025 (0xFE01); done_o 5 cycles after start.
- SX=0 or SY=0 -> no clr_o, no memz_we_o; done_o 1 cycle after start; busy_o stays 0.
- ACC_WIDTH=16, SX=SY=2, all samples 255 -> Z[1]=130050 mod 65536=64514; Z[0]=Z[2]=65025.
- start_i pulsed again during CALC, and size inputs changed mid-job -> ignored; results match the original sizes.
- rstn asserted during the WRITE of k=1 -> all outputs 0 immediately, state IDLE, no done_o; a new start then runs the full job correctly.
